// File: rtl/spn_cu_arbiter.sv
// spn_cu_arbiter
//   Round-robin arbiter/sequencer that shares one spn_cu_top core between
//   NUM_REQ requesters, one request at a time, and owns the 32-bit key
//   register feeding the core.
//
//   Optional feature: define SPN_ARB_WDT_EN to add a WAIT watchdog that
//   aborts with rsp_err=1 after WDT_CYCLES silent WAIT cycles.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : synchronous reset, active HIGH (name kept from codebase)
//   req_valid     : [NUM_REQ]     request valid per requester
//   req_ready     : [NUM_REQ]     one-hot grant (combinational in IDLE)
//   req_op        : [NUM_REQ*2]   opcode per requester, 01 enc / 10 dec
//   req_data      : [NUM_REQ*16]  data word per requester
//   rsp_valid     : [NUM_REQ]     one-hot response valid
//   rsp_ready     : [NUM_REQ]     response accept per requester
//   rsp_data      : [16]          shared response data
//   rsp_err       : [1]           response error flag
//   key_wr_en     : key write strobe
//   key_wr_data   : [32] new key
//   key_ready     : key write accepted this cycle
//   core_opcode   : [2]  to core opcode (non-zero only in ISSUE)
//   core_data_in  : [16] to core data_in
//   core_key      : [32] to core symmetric_secret_key
//   core_valid    : [2]  from core valid
//   core_data_out : [16] from core data_out
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | searching for a winner from rr_ptr; grant is combinational
// ISSUE  | core_opcode/core_data_in driven for exactly one cycle
// WAIT   | waiting for the core's registered valid
// RESP   | rsp_valid[idx] held with stable data/err until rsp_ready[idx]
module spn_cu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WDT_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*2-1:0]    req_op,
  input  logic [NUM_REQ*16-1:0]   req_data,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [15:0]             rsp_data,
  output logic                    rsp_err,
  input  logic                    key_wr_en,
  input  logic [31:0]             key_wr_data,
  output logic                    key_ready,
  output logic [1:0]              core_opcode,
  output logic [15:0]             core_data_in,
  output logic [31:0]             core_key,
  input  logic [1:0]              core_valid,
  input  logic [15:0]             core_data_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [1:0] OP_ENC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       op_q;
  logic [31:0]      key_q;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [1:0]       win_op;
  logic [15:0]      win_data;
  int               cand;

`ifdef SPN_ARB_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt;
`endif

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign win_op   = req_op[{win_idx, 1'b0} +: 2];
  assign win_data = req_data[{win_idx, 4'b0000} +: 16];

  // Grant and key_ready are combinational; both are forced low while reset
  // is asserted so that the outputs sit at their reset values.
  always_comb begin
    req_ready = '0;
    if (!rst_n && state == S_IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  assign key_ready = !rst_n && (state != S_ISSUE);
  assign core_key  = key_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      idx_q        <= '0;
      op_q         <= 2'b00;
      key_q        <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      core_opcode  <= 2'b00;
      core_data_in <= '0;
`ifdef SPN_ARB_WDT_EN
      wdt_cnt      <= '0;
`endif
    end else begin
      if (key_wr_en && key_ready) key_q <= key_wr_data;

      case (state)
        S_IDLE: begin
          if (win_found) begin
            idx_q <= win_idx;
            op_q  <= win_op;
            if (win_op == OP_ENC || win_op == OP_DEC) begin
              core_opcode  <= win_op;
              core_data_in <= win_data;
              state        <= S_ISSUE;
            end else begin
              // Illegal opcode: answer with an error, never touch the core.
              rsp_valid <= NUM_REQ'(1) << win_idx;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              state     <= S_RESP;
            end
          end
        end

        S_ISSUE: begin
          core_opcode  <= 2'b00;
          core_data_in <= '0;
`ifdef SPN_ARB_WDT_EN
          wdt_cnt      <= WDT_W'(WDT_CYCLES - 1);
`endif
          state        <= S_WAIT;
        end

        S_WAIT: begin
          if (core_valid == op_q) begin
            rsp_valid <= NUM_REQ'(1) << idx_q;
            rsp_data  <= core_data_out;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else if (core_valid != 2'b00) begin
            rsp_valid <= NUM_REQ'(1) << idx_q;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end
`ifdef SPN_ARB_WDT_EN
          // Down-counter reaches zero on the last permitted silent cycle.
          else if (wdt_cnt == '0) begin
            rsp_valid <= NUM_REQ'(1) << idx_q;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            wdt_cnt <= wdt_cnt - WDT_W'(1);
          end
`endif
        end

        S_RESP: begin
          if (rsp_ready[idx_q]) begin
            rsp_valid <= '0;
            rr_ptr    <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spn_cu_arbiter.md
# spn_cu_arbiter

Round-robin arbiter and sequencer that shares one `spn_cu_top` encryption/decryption core between `NUM_REQ` requesters. It accepts one request at a time over a per-requester valid/ready handshake. It drives the core's opcode and data for exactly one cycle, collects the registered result, and returns it to the granted requester. It also owns the 32-bit symmetric key register that feeds the core.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WDT_CYCLES`, default 8: watchdog limit in WAIT cycles. Used only with `SPN_ARB_WDT_EN`.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: synchronous, active-high reset. A high level resets on the next edge; the `_n` suffix follows the codebase port name.
- `req_valid`, input, `NUM_REQ`: per-requester request valid.
- `req_ready`, output, `NUM_REQ`: one-hot grant; at most one bit high.
- `req_op`, input, `NUM_REQ`×2: per-requester opcode. 01 = encrypt, 10 = decrypt, others illegal.
- `req_data`, input, `NUM_REQ`×16: per-requester data word.
- `rsp_valid`, output, `NUM_REQ`: one-hot response valid, raised toward the granted requester.
- `rsp_ready`, input, `NUM_REQ`: per-requester response accept.
- `rsp_data`, output, 16: shared response data.
- `rsp_err`, output, 1: response error flag.
- `key_wr_en`, input, 1: key write strobe.
- `key_wr_data`, input, 32: new key.
- `key_ready`, output, 1: key write accepted this cycle.
- `core_opcode`, output, 2: to core `opcode`.
- `core_data_in`, output, 16: to core `data_in`.
- `core_key`, output, 32: to core `symmetric_secret_key`.
- `core_valid`, input, 2: from core `valid`.
- `core_data_out`, input, 16: from core `data_out`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - The winner is the first requester with `req_valid`=1, searching from `rr_ptr` upward with wrap-around.
  - `req_ready[winner]`=1 combinationally in the same cycle.
  - On handshake, latch index, op and data.
  - If op is 01 or 10, go to ISSUE. Otherwise go to RESP with `rsp_err`=1 and `rsp_data`=0; the core is not touched.
- **ISSUE:** one cycle. `core_opcode` = latched op, `core_data_in` = latched data. Next state is WAIT.
- **WAIT:** `core_opcode`=00.
  - If `core_valid` equals the latched op: capture `core_data_out`, set err=0, go to RESP.
  - If `core_valid` is nonzero and does not match: set err=1, data=0, go to RESP.
  - If `core_valid`=00: stay in WAIT.
- **RESP:**
  - Drive `rsp_valid[idx]`=1 with `rsp_data` and `rsp_err` held stable.
  - On `rsp_ready[idx]`, go to IDLE and set `rr_ptr` = (idx+1) mod `NUM_REQ`.
  - `rsp_ready` of non-granted requesters is ignored.
- **Outside ISSUE:** `core_opcode`=00 and `core_data_in`=0.
- **Key register:** `core_key` = key register.
  - `key_ready` = (state != ISSUE).
  - `key_wr_en` && `key_ready` loads `key_wr_data` at the edge.
  - A write in the IDLE grant cycle takes effect for that request's ISSUE.
  - A write during ISSUE is not accepted; the writer holds `key_wr_en` until `key_ready`.
- `req_valid` dropping before handshake is allowed; no grant is recorded.
- **Reset:** the FSM goes to IDLE and `rr_ptr`=0. Reset mid-operation abandons the request with no response.
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `key_ready`=0, `core_opcode`=00, `core_data_in`=0, `core_key`=0.

## Timing
- Request handshake in cycle T.
- ISSUE in T+1; the core registers at the end of T+1.
- `core_valid` is visible in T+2 (WAIT).
- `rsp_valid` is high from T+3.
- Minimum service time is 4 cycles per request with `rsp_ready` held high. Maximum throughput is one request per 4 cycles.
- No new grant is issued while any state other than IDLE is active.
- Starvation bound: any requester holding `req_valid` is granted within `NUM_REQ` grants.

## Configuration
- **`SPN_ARB_WDT_EN` defined:**
  - A WAIT-cycle counter starts at 0 on WAIT entry.
  - If `WDT_CYCLES` WAIT cycles elapse with no nonzero `core_valid`, the arbiter goes to RESP with `rsp_err`=1 and `rsp_data`=0.
- **`SPN_ARB_WDT_EN` undefined:** no counter; WAIT persists until a nonzero `core_valid`.

## Test plan
- Key 0x1234ABCD written in IDLE. Requester 0 sends encrypt 0x0000 → `rsp_valid[0]` at T+3, `rsp_data` equals the golden 3-round SPN result, `rsp_err`=0.
- All `NUM_REQ`=4 requesters hold decrypt requests continuously → grants in order 0,1,2,3,0 with 4-cycle spacing; never two `req_ready` bits high at once.
- Requester 2 sends op 11 → `rsp_valid[2]` with `rsp_err`=1 and `rsp_data`=0; `core_opcode` stays 00 throughout.
- `rsp_ready` held low 5 cycles in RESP → `rsp_valid`/`rsp_data` stable; the pending request from requester 1 is not granted until after acceptance.
- `rst_n` high during WAIT → all outputs at reset values the next cycle; no `rsp_valid`; the next grant starts from requester 0.
- With `SPN_ARB_WDT_EN` and the core model forcing `core_valid`=00 → `rsp_err`=1 after exactly 8 WAIT cycles. A `core_valid`=10 answer to an encrypt request → `rsp_err`=1 immediately.
